// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: groups the scan request, selector and capture signals
// of mux_scan_ctrl. The optional scan_cnt signal exists only when the
// SCAN_CNT_EN macro is defined.
interface mux_scan_ctrl_if;
  logic       start;
  logic       hold;
  logic [2:0] m_in;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       done;
  logic [2:0] cap_u;
  logic [2:0] cap_v;
  logic [2:0] cap_w;
`ifdef SCAN_CNT_EN
  logic [7:0] scan_cnt;
`endif

  // Controller side: takes requests and selector data, drives select and results.
  modport slave (
    input  start, hold, m_in,
    output s1, s0, busy, done, cap_u, cap_v, cap_w
`ifdef SCAN_CNT_EN
    , output scan_cnt
`endif
  );

  // Requester side: issues scans and observes the results.
  modport master (
    output start, hold, m_in,
    input  s1, s0, busy, done, cap_u, cap_v, cap_w
`ifdef SCAN_CNT_EN
    , input scan_cnt
`endif
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an external 3-channel selector through u, v and w,
// waits SETTLE non-held cycles on each channel and captures the returned
// value. Optional feature macro: SCAN_CNT_EN adds an 8-bit count of
// completed scans.
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input logic        clk,
  input logic        rst_n,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEL_U,
    SEL_V,
    SEL_W,
    DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_settle;
  logic [3:0] w_settle_next;
  logic       w_capture;
  logic [2:0] r_cap_u;
  logic [2:0] r_cap_v;
  logic [2:0] r_cap_w;

  // Next-state and settle-count logic; capture fires on the last non-held settle cycle.
  always_comb begin
    w_next        = r_state;
    w_settle_next = r_settle;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        w_settle_next = 4'd0;
        if (bus.start) w_next = SEL_U;
      end
      SEL_U, SEL_V, SEL_W: begin
        if (!bus.hold) begin
          if (r_settle == LP_LAST) begin
            w_capture     = 1'b1;
            w_settle_next = 4'd0;
            case (r_state)
              SEL_U:   w_next = SEL_V;
              SEL_V:   w_next = SEL_W;
              default: w_next = DONE;
            endcase
          end else begin
            w_settle_next = r_settle + 4'd1;
          end
        end
      end
      DONE: begin
        w_settle_next = 4'd0;
        w_next        = IDLE;
      end
      default: begin
        w_settle_next = 4'd0;
        w_next        = IDLE;
      end
    endcase
  end

  // State register and settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_settle <= 4'd0;
    end else begin
      r_state  <= w_next;
      r_settle <= w_settle_next;
    end
  end

  // Capture registers: each loads only at the end of its own channel's settle window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_u <= 3'b000;
      r_cap_v <= 3'b000;
      r_cap_w <= 3'b000;
    end else if (w_capture) begin
      case (r_state)
        SEL_U:   r_cap_u <= bus.m_in;
        SEL_V:   r_cap_v <= bus.m_in;
        SEL_W:   r_cap_w <= bus.m_in;
        default: ;
      endcase
    end
  end

`ifdef SCAN_CNT_EN
  logic [7:0] r_scan_cnt;

  // Completed-scan counter, bumped on the edge that enters DONE and wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= 8'd0;
    end else if (w_capture && (r_state == SEL_W)) begin
      r_scan_cnt <= r_scan_cnt + 8'd1;
    end
  end

  assign bus.scan_cnt = r_scan_cnt;
`endif

  // Outputs are decoded from the state register only, so the select code never reads 11.
  assign bus.s1    = (r_state == SEL_W);
  assign bus.s0    = (r_state == SEL_V);
  assign bus.busy  = (r_state == SEL_U) || (r_state == SEL_V) || (r_state == SEL_W);
  assign bus.done  = (r_state == DONE);
  assign bus.cap_u = r_cap_u;
  assign bus.cap_v = r_cap_v;
  assign bus.cap_w = r_cap_w;

endmodule
